// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared encodings and the EX-stage control bundle for the TPFinal ID/EX control path.
// Byte-enable and shift fields are held at their 32-bit widths here and widened at the top level.
package tpfinal_ctrl_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_SLT = 4'b1001;

  localparam logic [1:0] SRC_REG   = 2'b00;
  localparam logic [1:0] SRC_SIMM  = 2'b01;
  localparam logic [1:0] SRC_ZIMM  = 2'b10;
  localparam logic [1:0] SRC_SHAMT = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic [1:0] alu_src;
    logic [4:0] shamt;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       branch_ne;
    logic       reg_dst;
    logic       load_unsigned;
    logic [3:0] rd_be;
    logic [3:0] wr_be;
    logic [4:0] dest;
    logic       illegal;
  } ctrl_t;

  function automatic logic [3:0] be_mask(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:         be_mask = 4'b1111;
      OP_LB, OP_LBU, OP_SB: be_mask = 4'b0001;
      OP_LH, OP_LHU, OP_SH: be_mask = 4'b0011;
      default:              be_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// ID-side request and EX-side control bundle of the decode pipe stage.
interface decode_ctrl_pipe_if #(parameter int DATA_W = 32);
  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int BE_W    = DATA_W / 8;

  logic [31:0]        instr_i;
  logic               instr_valid_i;
  logic               stall_i;
  logic               flush_i;
  logic               hazard_stall_o;
  logic               ex_valid_o;
  logic [3:0]         alu_ctrl_o;
  logic [1:0]         alu_src_o;
  logic [SHAMT_W-1:0] shamt_o;
  logic               reg_write_o;
  logic               mem_to_reg_o;
  logic               mem_write_o;
  logic               branch_o;
  logic               branch_ne_o;
  logic               reg_dst_o;
  logic               load_unsigned_o;
  logic [BE_W-1:0]    rd_be_o;
  logic [BE_W-1:0]    wr_be_o;
  logic [4:0]         ex_dest_o;
  logic               illegal_o;

  modport master (
    output instr_i, instr_valid_i, stall_i, flush_i,
    input  hazard_stall_o, ex_valid_o, alu_ctrl_o, alu_src_o, shamt_o, reg_write_o,
           mem_to_reg_o, mem_write_o, branch_o, branch_ne_o, reg_dst_o, load_unsigned_o,
           rd_be_o, wr_be_o, ex_dest_o, illegal_o
  );

  modport slave (
    input  instr_i, instr_valid_i, stall_i, flush_i,
    output hazard_stall_o, ex_valid_o, alu_ctrl_o, alu_src_o, shamt_o, reg_write_o,
           mem_to_reg_o, mem_write_o, branch_o, branch_ne_o, reg_dst_o, load_unsigned_o,
           rd_be_o, wr_be_o, ex_dest_o, illegal_o
  );
endinterface

// File: rtl/decode_ctrl_pipe_ctrl_decode.sv
// Combinational decode of one instruction word into the EX control bundle,
// plus which source registers the instruction actually reads.
module ctrl_decode
  import tpfinal_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        reads_rs_o,
  output logic        reads_rt_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o
);
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rd;
  logic       ill;

  assign op    = instr_i[31:26];
  assign rs_o  = instr_i[25:21];
  assign rt_o  = instr_i[20:16];
  assign rd    = instr_i[15:11];
  assign funct = instr_i[5:0];

  always_comb begin
    ctrl_o       = '0;
    ill          = 1'b0;
    reads_rs_o   = 1'b1;
    reads_rt_o   = 1'b0;
    ctrl_o.shamt = instr_i[10:6];
    case (op)
      OP_RTYPE: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        reads_rt_o       = 1'b1;
        case (funct)
          FN_ADD:  ctrl_o.alu_ctrl = ALU_ADD;
          FN_SUB:  ctrl_o.alu_ctrl = ALU_SUB;
          FN_AND:  ctrl_o.alu_ctrl = ALU_AND;
          FN_OR:   ctrl_o.alu_ctrl = ALU_OR;
          FN_XOR:  ctrl_o.alu_ctrl = ALU_XOR;
          FN_NOR:  ctrl_o.alu_ctrl = ALU_NOR;
          FN_SLT:  ctrl_o.alu_ctrl = ALU_SLT;
          FN_SLLV: ctrl_o.alu_ctrl = ALU_SLL;
          FN_SRLV: ctrl_o.alu_ctrl = ALU_SRL;
          FN_SRAV: ctrl_o.alu_ctrl = ALU_SRA;
          FN_SLL:  begin ctrl_o.alu_ctrl = ALU_SLL; ctrl_o.alu_src = SRC_SHAMT; reads_rs_o = 1'b0; end
          FN_SRL:  begin ctrl_o.alu_ctrl = ALU_SRL; ctrl_o.alu_src = SRC_SHAMT; reads_rs_o = 1'b0; end
          FN_SRA:  begin ctrl_o.alu_ctrl = ALU_SRA; ctrl_o.alu_src = SRC_SHAMT; reads_rs_o = 1'b0; end
          default: ill = 1'b1;
        endcase
      end
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
        ctrl_o.alu_src       = SRC_SIMM;
        ctrl_o.mem_to_reg    = 1'b1;
        ctrl_o.reg_write     = 1'b1;
        ctrl_o.load_unsigned = (op == OP_LBU) || (op == OP_LHU);
        ctrl_o.rd_be         = be_mask(op);
      end
      OP_SW, OP_SB, OP_SH: begin
        ctrl_o.alu_src   = SRC_SIMM;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.wr_be     = be_mask(op);
        reads_rt_o       = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_o.alu_ctrl  = ALU_SUB;
        ctrl_o.branch    = 1'b1;
        ctrl_o.branch_ne = (op == OP_BNE);
        reads_rt_o       = 1'b1;
      end
      OP_ADDI: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_ctrl = ALU_ADD; ctrl_o.alu_src = SRC_SIMM; end
      OP_SLTI: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_ctrl = ALU_SLT; ctrl_o.alu_src = SRC_SIMM; end
      OP_ANDI: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_ctrl = ALU_AND; ctrl_o.alu_src = SRC_ZIMM; end
      OP_ORI:  begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_ctrl = ALU_OR;  ctrl_o.alu_src = SRC_ZIMM; end
      OP_XORI: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_ctrl = ALU_XOR; ctrl_o.alu_src = SRC_ZIMM; end
      OP_LUI: begin
        // LUI is executed as imm << 16 on the shifter
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_ctrl  = ALU_SLL;
        ctrl_o.alu_src   = SRC_ZIMM;
        ctrl_o.shamt     = 5'd16;
        reads_rs_o       = 1'b0;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      ctrl_o         = '0;
      ctrl_o.illegal = 1'b1;
      ctrl_o.shamt   = instr_i[10:6];
      reads_rs_o     = 1'b0;
      reads_rt_o     = 1'b0;
    end
    ctrl_o.dest = ctrl_o.reg_dst ? rd : rt_o;
  end
endmodule

// File: rtl/decode_ctrl_pipe.sv
// ID/EX control register with load-use bubble insertion, stall hold and flush.
// Update order per edge: reset, flush, stall, hazard bubble, then the decoded instruction.
module decode_ctrl_pipe
  import tpfinal_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  decode_ctrl_pipe_if.slave bus
);
  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int BE_W    = DATA_W / 8;

  ctrl_t      dec;
  logic       reads_rs;
  logic       reads_rt;
  logic [4:0] rs;
  logic [4:0] rt;
  ctrl_t      ex_q, ex_d;
  logic       ex_valid_q, ex_valid_d;
  logic       hazard;

  ctrl_decode u_decode (
    .instr_i    (bus.instr_i),
    .ctrl_o     (dec),
    .reads_rs_o (reads_rs),
    .reads_rt_o (reads_rt),
    .rs_o       (rs),
    .rt_o       (rt)
  );

  // Gated by ex_valid_q so a reset EX register can never request a stall
  always_comb begin
    hazard = ex_valid_q && ex_q.mem_to_reg && (ex_q.dest != 5'd0) && bus.instr_valid_i &&
             ((reads_rs && (rs == ex_q.dest)) || (reads_rt && (rt == ex_q.dest)));
  end

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (bus.flush_i) begin
      ex_d       = '0;
      ex_valid_d = 1'b0;
    end else if (bus.stall_i) begin
      ex_d       = ex_q;
      ex_valid_d = ex_valid_q;
    end else if (hazard || !bus.instr_valid_i) begin
      ex_d       = '0;
      ex_valid_d = 1'b0;
    end else begin
      ex_d       = dec;
      ex_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign bus.hazard_stall_o  = hazard;
  assign bus.ex_valid_o      = ex_valid_q;
  assign bus.alu_ctrl_o      = ex_q.alu_ctrl;
  assign bus.alu_src_o       = ex_q.alu_src;
  assign bus.shamt_o         = SHAMT_W'(ex_q.shamt);
  assign bus.reg_write_o     = ex_q.reg_write;
  assign bus.mem_to_reg_o    = ex_q.mem_to_reg;
  assign bus.mem_write_o     = ex_q.mem_write;
  assign bus.branch_o        = ex_q.branch;
  assign bus.branch_ne_o     = ex_q.branch_ne;
  assign bus.reg_dst_o       = ex_q.reg_dst;
  assign bus.load_unsigned_o = ex_q.load_unsigned;
  assign bus.rd_be_o         = BE_W'(ex_q.rd_be);
  assign bus.wr_be_o         = BE_W'(ex_q.wr_be);
  assign bus.ex_dest_o       = ex_q.dest;
  assign bus.illegal_o       = ex_q.illegal;
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: decode table, hazard/stall/flush sequences and
// randomized traffic against a rule-level model; 32- and 64-bit instances run in lockstep.
module tb_decode_ctrl_pipe;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_ctrl_pipe_if #(.DATA_W(32)) b32 ();
  decode_ctrl_pipe_if #(.DATA_W(64)) b64 ();

  decode_ctrl_pipe #(.DATA_W(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
  decode_ctrl_pipe #(.DATA_W(64)) dut64 (.clk(clk), .reset(reset), .bus(b64.slave));

  assign b64.instr_i       = b32.instr_i;
  assign b64.instr_valid_i = b32.instr_valid_i;
  assign b64.stall_i       = b32.stall_i;
  assign b64.flush_i       = b32.flush_i;

  // fl = {reg_write, mem_to_reg, mem_write, branch, branch_ne, reg_dst, load_unsigned}
  typedef struct packed {
    logic       v;
    logic [3:0] alu;
    logic [1:0] src;
    logic [4:0] sh;
    logic [6:0] fl;
    logic [3:0] rbe;
    logic [3:0] wbe;
    logic [4:0] dst;
    logic       ill;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] w;
    exp_t        e;
  } vec_t;

  vec_t vt[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(input logic [3:0] alu, input logic [1:0] src, input logic [4:0] sh,
                              input logic [6:0] fl, input logic [3:0] rbe, input logic [3:0] wbe,
                              input logic [4:0] dst, input logic ill);
    exp_t e;
    e.v = 1'b1; e.alu = alu; e.src = src; e.sh = sh; e.fl = fl;
    e.rbe = rbe; e.wbe = wbe; e.dst = dst; e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t got32();
    exp_t e;
    e.v   = b32.ex_valid_o;  e.alu = b32.alu_ctrl_o; e.src = b32.alu_src_o; e.sh = b32.shamt_o;
    e.fl  = {b32.reg_write_o, b32.mem_to_reg_o, b32.mem_write_o, b32.branch_o,
             b32.branch_ne_o, b32.reg_dst_o, b32.load_unsigned_o};
    e.rbe = b32.rd_be_o; e.wbe = b32.wr_be_o; e.dst = b32.ex_dest_o; e.ill = b32.illegal_o;
    return e;
  endfunction

  // 64-bit view: low fields as exp_t, followed by the bits that must stay zero
  function automatic logic [41:0] got64();
    exp_t e;
    e.v   = b64.ex_valid_o;  e.alu = b64.alu_ctrl_o; e.src = b64.alu_src_o; e.sh = b64.shamt_o[4:0];
    e.fl  = {b64.reg_write_o, b64.mem_to_reg_o, b64.mem_write_o, b64.branch_o,
             b64.branch_ne_o, b64.reg_dst_o, b64.load_unsigned_o};
    e.rbe = b64.rd_be_o[3:0]; e.wbe = b64.wr_be_o[3:0]; e.dst = b64.ex_dest_o; e.ill = b64.illegal_o;
    return {e, b64.shamt_o[5], b64.rd_be_o[7:4], b64.wr_be_o[7:4]};
  endfunction

  // Reference decode written straight from the instruction tables
  function automatic void ref_dec(input logic [31:0] w, output exp_t e, output logic rrs, output logic rrt);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26]; fn = w[5:0];
    e = '0; e.v = 1'b1; e.sh = w[10:6]; rrs = 1'b1; rrt = 1'b0;
    if (op == 6'h00) begin
      rrt = 1'b1; e.fl = 7'b1000010;
      case (fn)
        6'h20: e.alu = 4'd0;  6'h22: e.alu = 4'd1;  6'h24: e.alu = 4'd2;  6'h25: e.alu = 4'd3;
        6'h26: e.alu = 4'd4;  6'h27: e.alu = 4'd5;  6'h2a: e.alu = 4'd9;
        6'h04: e.alu = 4'd6;  6'h06: e.alu = 4'd7;  6'h07: e.alu = 4'd8;
        6'h00: begin e.alu = 4'd6; e.src = 2'd3; rrs = 1'b0; end
        6'h02: begin e.alu = 4'd7; e.src = 2'd3; rrs = 1'b0; end
        6'h03: begin e.alu = 4'd8; e.src = 2'd3; rrs = 1'b0; end
        default: e.ill = 1'b1;
      endcase
    end else begin
      case (op)
        6'h23, 6'h20, 6'h24, 6'h21, 6'h25: begin
          e.src = 2'd1;
          e.fl  = {2'b11, 4'b0000, (op == 6'h24 || op == 6'h25)};
          e.rbe = (op == 6'h23) ? 4'hF : (op == 6'h20 || op == 6'h24) ? 4'h1 : 4'h3;
        end
        6'h2b, 6'h28, 6'h29: begin
          e.src = 2'd1; e.fl = 7'b0010000; rrt = 1'b1;
          e.wbe = (op == 6'h2b) ? 4'hF : (op == 6'h28) ? 4'h1 : 4'h3;
        end
        6'h04, 6'h05: begin e.alu = 4'd1; e.fl = {3'b000, 1'b1, op[0], 2'b00}; rrt = 1'b1; end
        6'h08: begin e.alu = 4'd0; e.src = 2'd1; e.fl = 7'b1000000; end
        6'h0a: begin e.alu = 4'd9; e.src = 2'd1; e.fl = 7'b1000000; end
        6'h0c: begin e.alu = 4'd2; e.src = 2'd2; e.fl = 7'b1000000; end
        6'h0d: begin e.alu = 4'd3; e.src = 2'd2; e.fl = 7'b1000000; end
        6'h0e: begin e.alu = 4'd4; e.src = 2'd2; e.fl = 7'b1000000; end
        6'h0f: begin e.alu = 4'd6; e.src = 2'd2; e.fl = 7'b1000000; e.sh = 5'd16; rrs = 1'b0; end
        default: e.ill = 1'b1;
      endcase
    end
    if (e.ill) begin
      e.alu = '0; e.src = '0; e.fl = '0; e.rbe = '0; e.wbe = '0; rrs = 1'b0; rrt = 1'b0;
    end
    e.dst = e.fl[1] ? w[15:11] : w[20:16];
  endfunction

  function automatic logic ref_haz(input exp_t ex, input logic [31:0] w, input logic iv);
    exp_t d;
    logic rrs, rrt;
    ref_dec(w, d, rrs, rrt);
    return ex.v && ex.fl[5] && (ex.dst != 5'd0) && iv &&
           ((rrs && (w[25:21] == ex.dst)) || (rrt && (w[20:16] == ex.dst)));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] w, input logic iv, input logic st, input logic fl);
    b32.instr_i = w; b32.instr_valid_i = iv; b32.stall_i = st; b32.flush_i = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string n, input logic [31:0] w, input exp_t e);
    vec_t t;
    t.name = n; t.w = w; t.e = e;
    vt.push_back(t);
  endtask

  localparam logic [31:0] I_LW    = 32'h8C250004;
  localparam logic [31:0] I_LB    = 32'h80250000;
  localparam logic [31:0] I_LUI   = 32'h3C041234;
  localparam logic [31:0] I_ADD3  = 32'h00221820;

  logic [31:0] i_add6, i_ori, i_sub, i_lbu, w;
  exp_t        e_lw, e_ori, e_add6, m, d;
  logic        iv, st, fl, hz, rrs, rrt;
  logic [5:0]  ops [17];
  logic [5:0]  fns [13];

  initial begin
    ops = '{6'h00, 6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'h2b, 6'h28, 6'h29,
            6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    i_add6 = rtype(5'd5, 5'd2, 5'd6, 5'd0, 6'h20);
    i_ori  = itype(6'h0d, 5'd1, 5'd8, 16'hFFFF);
    i_sub  = rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h22);
    i_lbu  = itype(6'h24, 5'd1, 5'd7, 16'h0000);
    e_lw   = mk(4'd0, 2'd1, 5'd0,  7'b1100000, 4'hF, 4'h0, 5'd5, 1'b0);
    e_ori  = mk(4'd3, 2'd2, 5'd31, 7'b1000000, 4'h0, 4'h0, 5'd8, 1'b0);
    e_add6 = mk(4'd0, 2'd0, 5'd0,  7'b1000010, 4'h0, 4'h0, 5'd6, 1'b0);

    add_vec("add",       I_ADD3,                                   mk(4'd0, 2'd0, 5'd0,  7'b1000010, 4'h0, 4'h0, 5'd3,  1'b0));
    add_vec("sub",       i_sub,                                    mk(4'd1, 2'd0, 5'd0,  7'b1000010, 4'h0, 4'h0, 5'd4,  1'b0));
    add_vec("sll",       rtype(5'd0, 5'd2, 5'd5, 5'd7, 6'h00),     mk(4'd6, 2'd3, 5'd7,  7'b1000010, 4'h0, 4'h0, 5'd5,  1'b0));
    add_vec("srav",      rtype(5'd3, 5'd2, 5'd6, 5'd0, 6'h07),     mk(4'd8, 2'd0, 5'd0,  7'b1000010, 4'h0, 4'h0, 5'd6,  1'b0));
    add_vec("slt",       rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'h2a),     mk(4'd9, 2'd0, 5'd0,  7'b1000010, 4'h0, 4'h0, 5'd7,  1'b0));
    add_vec("lw",        I_LW,                                     e_lw);
    add_vec("lhu",       itype(6'h25, 5'd1, 5'd6, 16'h0040),       mk(4'd0, 2'd1, 5'd1,  7'b1100001, 4'h3, 4'h0, 5'd6,  1'b0));
    add_vec("sb",        itype(6'h28, 5'd1, 5'd2, 16'h0000),       mk(4'd0, 2'd1, 5'd0,  7'b0010000, 4'h0, 4'h1, 5'd2,  1'b0));
    add_vec("bne",       itype(6'h05, 5'd1, 5'd2, 16'h0008),       mk(4'd1, 2'd0, 5'd0,  7'b0001100, 4'h0, 4'h0, 5'd2,  1'b0));
    add_vec("ori",       i_ori,                                    e_ori);
    add_vec("lui",       I_LUI,                                    mk(4'd6, 2'd2, 5'd16, 7'b1000000, 4'h0, 4'h0, 5'd4,  1'b0));
    add_vec("ill_op",    itype(6'h3f, 5'd1, 5'd9, 16'h0000),       mk(4'd0, 2'd0, 5'd0,  7'b0000000, 4'h0, 4'h0, 5'd9,  1'b1));
    add_vec("ill_funct", rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h08),     mk(4'd0, 2'd0, 5'd0,  7'b0000000, 4'h0, 4'h0, 5'd2,  1'b1));
    add_vec("slti",      itype(6'h0a, 5'd1, 5'd10, 16'h0005),      mk(4'd9, 2'd1, 5'd0,  7'b1000000, 4'h0, 4'h0, 5'd10, 1'b0));

    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("reset_ex32", got32(), '0);
    chk("reset_ex64", got64(), '0);
    chk("reset_haz", b32.hazard_stall_o, 1'b0);
    reset = 1'b0;

    foreach (vt[i]) begin
      drive(32'h0, 1'b0, 1'b0, 1'b0); tick();
      drive(vt[i].w, 1'b1, 1'b0, 1'b0); tick();
      chk(vt[i].name, got32(), vt[i].e);
      chk({vt[i].name, "_64"}, got64(), {vt[i].e, 9'b0});
    end

    // Load-use: one bubble, then the dependent ADD goes through
    drive(I_LW, 1'b1, 1'b0, 1'b0); tick();
    drive(i_add6, 1'b1, 1'b0, 1'b0); #1;
    chk("lu_haz_on", b32.hazard_stall_o, 1'b1);
    tick();
    chk("lu_bubble", got32(), '0);
    chk("lu_haz_off", b32.hazard_stall_o, 1'b0);
    tick();
    chk("lu_add", got32(), e_add6);

    drive(I_LB, 1'b1, 1'b0, 1'b0); tick();
    chk("lb_be_lu", {b32.rd_be_o, b32.load_unsigned_o}, {4'b0001, 1'b0});
    chk("lb_be64", b64.rd_be_o, 8'h01);
    drive(i_lbu, 1'b1, 1'b0, 1'b0); tick();
    chk("lbu_be_lu", {b32.rd_be_o, b32.load_unsigned_o}, {4'b0001, 1'b1});
    chk("lbu_be64", b64.rd_be_o, 8'h01);

    drive(I_LW, 1'b1, 1'b0, 1'b0); tick();
    drive(i_add6, 1'b1, 1'b0, 1'b1); #1;
    chk("fl_haz_on", b32.hazard_stall_o, 1'b1);
    tick();
    chk("fl_bubble", got32(), '0);
    drive(i_add6, 1'b1, 1'b0, 1'b0); #1;
    chk("fl_haz_off", b32.hazard_stall_o, 1'b0);
    tick();
    chk("fl_add", got32(), e_add6);

    drive(i_ori, 1'b1, 1'b0, 1'b0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(i_sub, 1'b1, 1'b1, 1'b0); tick();
      chk("stall_hold", got32(), e_ori);
    end
    drive(i_sub, 1'b1, 1'b0, 1'b0); tick();
    chk("stall_release", got32(), mk(4'd1, 2'd0, 5'd0, 7'b1000010, 4'h0, 4'h0, 5'd4, 1'b0));

    // Stall while a hazard is pending, then reset in the middle of it
    drive(I_LW, 1'b1, 1'b0, 1'b0); tick();
    drive(i_add6, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("sh_hold", got32(), e_lw);
      chk("sh_haz", b32.hazard_stall_o, 1'b1);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_mid_ex", got32(), '0);
    chk("rst_mid_haz", b32.hazard_stall_o, 1'b0);
    drive(i_add6, 1'b1, 1'b0, 1'b0); tick();
    chk("rst_mid_add", got32(), e_add6);

    reset = 1'b1; drive(32'h0, 1'b0, 1'b0, 1'b0); tick(); reset = 1'b0;
    m = '0;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 15) == 0) w = $urandom;
      else begin
        logic [5:0] op;
        op = ops[$urandom_range(0, 16)];
        if (op == 6'h00)
          w = rtype(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 31)), fns[$urandom_range(0, 12)]);
        else
          w = itype(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom));
      end
      iv = ($urandom_range(0, 7) != 0);
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 63) == 0);
      drive(w, iv, st, fl); #1;
      hz = ref_haz(m, w, iv);
      chk("rnd_haz", b32.hazard_stall_o, hz);
      ref_dec(w, d, rrs, rrt);
      if (reset || fl) m = '0;
      else if (st) m = m;
      else if (hz || !iv) m = '0;
      else m = d;
      tick();
      chk("rnd_ex32", got32(), m);
      chk("rnd_ex64", got64(), {m, 9'b0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered successor of the combinational MIPS control decoder: decodes a full 32-bit instruction word into the EX-stage control bundle and holds it in an ID/EX control register. Adds stall/flush handling, load-use hazard detection with bubble insertion, illegal-instruction flagging, and a data-width parameter that scales shift-amount and byte-enable widths. Sits between the IF/ID instruction register and the ALU/memory stages of the TPFinal pipeline.

## Interface
- DATA_W, 32, datapath width; legal values 32 or 64. Derived: SHAMT_W = $clog2(DATA_W); BE_W = DATA_W/8.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr_i  in  32  instruction from IF/ID.
- instr_valid_i  in  1  instr_i holds a real instruction.
- stall_i  in  1  downstream hold; EX register keeps its value.
- flush_i  in  1  kill: EX register becomes a bubble.
- hazard_stall_o  out  1  combinational load-use stall request to IF/ID.
- ex_valid_o  out  1  EX register holds a real instruction.
- alu_ctrl_o  out  4  ALU operation code.
- alu_src_o  out  2  00 reg B, 01 sign-ext imm, 10 zero-ext imm, 11 shamt.
- shamt_o  out  SHAMT_W  shift amount (instr[10:6] zero-extended, or 16 for LUI).
- reg_write_o, mem_to_reg_o, mem_write_o, branch_o, branch_ne_o, reg_dst_o, load_unsigned_o  out  1 each  control flags.
- rd_be_o, wr_be_o  out  BE_W  read/write byte lanes.
- ex_dest_o  out  5  destination register (rd if reg_dst_o, else rt).
- illegal_o  out  1  unknown opcode/funct in EX.

## Operation
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOR 0101, SLL 0110, SRL 0111, SRA 1000, SLT 1001.
- R-type (op 000000): reg_write=1, reg_dst=1. funct ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010 use src 00. SLL 000000, SRL 000010, SRA 000011 use src 11. SLLV 000100, SRLV 000110, SRAV 000111 use src 00.
- Loads, src 01, ALU ADD, mem_to_reg=1, reg_write=1: LW 100011 (be 1111), LB 100000 / LBU 100100 (be 0001), LH 100001 / LHU 100101 (be 0011). load_unsigned=1 for LBU and LHU.
- Stores, src 01, ALU ADD, mem_write=1: SW 101011 (1111), SB 101000 (0001), SH 101001 (0011).
- BEQ 000100 and BNE 000101: branch=1, ALU SUB, src 00. branch_ne=1 for BNE only.
- Immediates, reg_write=1: ADDI 001000 (ADD, src 01), SLTI 001010 (SLT, 01), ANDI 001100 (AND, 10), ORI 001101 (OR, 10), XORI 001110 (XOR, 10). LUI 001111 uses SLL, src 10, shamt=16.
- Byte enables are placed in the lowest lanes; the upper BE_W-4 lanes are 0 when DATA_W=64. Non-memory instructions drive rd_be=wr_be=0.
- Illegal op/funct: all write, memory and branch flags are 0, illegal_o=1, ex_valid_o=1.
- Load-use hazard: EX holds a valid load with ex_dest≠0, and the decoding valid instruction reads that register. Reads are rs (all except SLL/SRL/SRA/LUI) and rt (R-type, stores, BEQ/BNE). hazard_stall_o=1.

## Timing
- Register update priority per edge: reset > flush_i > stall_i (hold) > hazard (load bubble) > load decoded instruction.
- Reset: all outputs 0, ex_valid_o=0, hazard_stall_o=0 (it is gated by ex_valid).
- Decode latency is 1 cycle, from instr_i to the EX outputs.
- Bubble: ex_valid=0 and all control fields 0.
- instr_valid_i=0 loads a bubble.
- Hazard: exactly one bubble is inserted. IF/ID holds instr_i, and the next cycle decodes it normally because EX no longer holds the load.
- flush_i together with hazard: flush wins. hazard_stall_o stays combinational and is ignored upstream on flush.
- stall_i during a hazard: EX holds. hazard_stall_o stays asserted.
- Reset mid-stall: the bubble is cleared immediately and there is no residual stall.

## Structure
- Package tpfinal_ctrl_pkg: ALU code localparams, opcode/funct localparams, alu_src encodings, and a packed ctrl_t struct for the bundle.
- Sub-module ctrl_decode: purely combinational decode of instr_i into ctrl_t.
- The top level holds the ID/EX register, the hazard detector and the priority logic.

## Test plan
- Reset is held 2 cycles, then ADD $3,$1,$2 (0x00221820): next cycle ex_valid=1, alu_ctrl=0000, reg_dst=1, ex_dest=3.
- LW $5,4($1) (0x8C250004) followed by ADD $6,$5,$2: hazard_stall_o=1 for 1 cycle, one bubble is inserted, then ADD is decoded with alu_ctrl=0000.
- LB (0x80250000) then LBU: rd_be=0001 for both; load_unsigned 0 then 1. With DATA_W=64, rd_be=8'h01.
- LUI $4,0x1234 (0x3C041234): alu_ctrl=0110, alu_src=10, shamt_o=16, reg_write=1.
- flush_i on the same cycle as a hazard: EX becomes a bubble. stall_i held 3 cycles: outputs stay constant.
- Opcode 111111: illegal_o=1, reg_write=mem_write=branch=0.
